regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Write-port controller for the 32-entry MIPS32 general-purpose register file. It shares the file's single write port between the pipeline writeback stage and the multicycle mult/div unit. A 31-bit scoreboard tracks registers owed a mult/div result and flags read hazards to issue. A starvation counter forces a one-cycle pipeline freeze so mult/div results are never blocked indefinitely.

## Interface
- MD_STARVE_MAX, 4, consecutive blocked mult/div cycles before a forced stall; legal range 1..15
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wbWrite  in  1  writeback stage requests a register write this cycle
- wbAddr  in  5  writeback destination
- wbData  in  32  writeback value
- mdValid  in  1  mult/div result pending; held with mdAddr/mdData until mdReady
- mdAddr  in  5  mult/div destination
- mdData  in  32  mult/div result
- mdReady  out  1  mult/div result accepted this cycle
- issueMd  in  1  a mult/div op with destination issueAddr issues this cycle
- issueAddr  in  5  destination of the issuing mult/div op
- rs, rt  in  5  source registers of the instruction in decode
- hazard  out  1  rs or rt is awaiting a mult/div result
- pipeStall  out  1  registered; freezes the pipeline for one cycle
- regWrite  out  1  register file write enable
- rWriteAddress  out  5  register file write address
- rWriteValue  out  32  register file write data

## Operation
- FSM states:
  - RUN (reset state).
  - STALL: lasts exactly one cycle, then always returns to RUN.
- Grant in RUN:
  - wbWrite=1: WB wins.
  - else mdValid=1: MD wins.
- Grant in STALL: MD wins unconditionally. The pipeline is frozen, and the arbiter ignores wb inputs this cycle. The held WB write is re-presented next cycle.
- mdReady = mdValid and MD granted (combinational).
- Write port:
  - regWrite = granted requester present and its address ≠ 0.
  - rWriteAddress/rWriteValue are muxed from the winner.
  - A write to address 0 is dropped (regWrite=0), but mdReady still completes the handshake.
- Starvation counter starveCnt, width 4:
  - In RUN with mdValid=1 and wbWrite=1 (MD blocked), starveCnt increments.
  - If it reaches MD_STARVE_MAX on that edge, the next state is STALL and pipeStall goes to 1.
  - Any MD grant clears starveCnt.
  - In RUN with mdValid=0, starveCnt is cleared.
- Scoreboard busy[31:1]:
  - issueMd with issueAddr≠0 sets busy[issueAddr].
  - An MD grant with mdAddr≠0 clears busy[mdAddr].
  - Set and clear of the same address in the same cycle: set wins.
  - Bit 0 does not exist.
- hazard = (rs≠0 and busy[rs]) or (rt≠0 and busy[rt]), from registered busy.
  - No bypass: hazard stays 1 in the cycle the result is written and drops the next cycle.
- Protocol violations are undefined; no detection required:
  - mdValid dropping without mdReady.
  - issueMd to an already-busy register.

## Timing
- Reset (rst=1 at edge): state=RUN, starveCnt=0, busy=0, pipeStall=0.
- While rst=1: regWrite=0, mdReady=0, hazard=0 are forced combinationally.
- Write latency: the request is presented in cycle N and the register file captures it at the end of N. Read data reflects it in N+1.
- Stall timing (MD_STARVE_MAX=4): MD is blocked in cycles N..N+3, pipeStall=1 in N+4, and MD is written in N+4.
- pipeStall is asserted at most 1 cycle in any MD_STARVE_MAX+1 cycles.
- Reset mid-handshake: the pending MD result is lost and busy is cleared. The mult/div unit is reset by the same rst.

## Structure
- Shared package mips32_pkg:
  - REG_ADDR_W=5, DATA_W=32.
  - Arbiter state enum {RUN, STALL}.
  - Zero-register constant.
- Sub-module regfile_scoreboard holds busy[31:1] with its set/clear/hazard logic. The arbiter FSM, counter and write mux remain in the top.

## Test plan
- Reset then idle: all outputs 0; wbWrite=1, wbAddr=5, wbData=0xDEADBEEF -> regWrite=1, rWriteAddress=5, rWriteValue=0xDEADBEEF same cycle.
- Scoreboard: issueMd, issueAddr=9; next cycle rs=9 -> hazard=1. MD returns mdAddr=9 with wbWrite=0 -> mdReady=1, regWrite=1, and hazard=0 the following cycle.
- Contention: mdValid=1 and wbWrite=1 held continuously (MD_STARVE_MAX=4):
  - Cycles 0-3: WB written, mdReady=0.
  - Cycle 4: pipeStall=1, MD written.
  - Cycle 5: pipeStall=0 and WB resumes.
- Zero register: wbWrite=1, wbAddr=0 -> regWrite=0; mdValid with mdAddr=0 -> mdReady=1, regWrite=0; issueMd with issueAddr=0 -> hazard stays 0 for rs=0.
- Same-cycle set/clear: issueMd to register 3 in the same cycle MD completes register 3 -> busy[3]=1 afterwards, hazard=1 for rt=3.
- Reset during STALL and with busy bits set -> next cycle pipeStall=0, hazard=0, state RUN, starveCnt=0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared widths, arbiter state encoding and register-file constants for the MIPS32 core.
package mips32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Tracks GPRs owed a mult/div result; hazard is combinational from the registered busy bits.
// A set and a clear to the same register in one cycle leaves the register busy.
module regfile_scoreboard
    import mips32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hazard
);

    logic [31:1] busy;
    logic [31:1] busy_next;
    logic [31:0] busy_vec;

    // $zero never gets a busy bit, so looking it up always yields 0.
    assign busy_vec = {busy, 1'b0};

    always_comb begin
        busy_next = busy;
        for (int i = 1; i < 32; i++) begin
            if (set_en && set_addr == REG_ADDR_W'(i)) begin
                busy_next[i] = 1'b1;
            end else if (clr_en && clr_addr == REG_ADDR_W'(i)) begin
                busy_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard = !rst && (busy_vec[rs] || busy_vec[rt]);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the GPR write port between writeback and mult/div; the write lands the cycle it is granted.
// Writeback has priority; mult/div starved for MD_STARVE_MAX cycles forces a one-cycle pipeline stall.
module regfile_write_arbiter
    import mips32_pkg::*;
#(
    parameter int MD_STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wbWrite,
    input  logic [REG_ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0]     wbData,
    input  logic                  mdValid,
    input  logic [REG_ADDR_W-1:0] mdAddr,
    input  logic [DATA_W-1:0]     mdData,
    output logic                  mdReady,
    input  logic                  issueMd,
    input  logic [REG_ADDR_W-1:0] issueAddr,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hazard,
    output logic                  pipeStall,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] rWriteAddress,
    output logic [DATA_W-1:0]     rWriteValue
);

    localparam logic [3:0] STARVE_LIM = 4'(MD_STARVE_MAX);

    arb_state_t state;
    arb_state_t state_next;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    logic       wb_gnt;
    logic       md_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        wb_gnt          = 1'b0;
        md_gnt          = 1'b0;
        case (state)
            RUN: begin
                if (wbWrite) begin
                    wb_gnt = 1'b1;
                    if (mdValid) begin
                        starve_cnt_next = starve_cnt + 4'd1;
                        if (starve_cnt_next >= STARVE_LIM) begin
                            state_next = STALL;
                        end
                    end else begin
                        starve_cnt_next = '0;
                    end
                end else if (mdValid) begin
                    md_gnt          = 1'b1;
                    starve_cnt_next = '0;
                end else begin
                    starve_cnt_next = '0;
                end
            end
            STALL: begin
                // Pipeline is frozen, so any writeback request is re-presented next cycle.
                md_gnt          = mdValid;
                starve_cnt_next = '0;
                state_next      = RUN;
            end
            default: begin
                state_next      = RUN;
                starve_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        rWriteAddress = ZERO_REG;
        rWriteValue   = '0;
        if (md_gnt) begin
            rWriteAddress = mdAddr;
            rWriteValue   = mdData;
        end else if (wb_gnt) begin
            rWriteAddress = wbAddr;
            rWriteValue   = wbData;
        end
    end

    assign mdReady   = !rst && md_gnt;
    assign regWrite  = !rst && ((wb_gnt && wbAddr != ZERO_REG) ||
                                (md_gnt && mdAddr != ZERO_REG));
    assign pipeStall = (state == STALL);

    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issueMd),
        .set_addr (issueAddr),
        .clr_en   (mdReady),
        .clr_addr (mdAddr),
        .rs       (rs),
        .rt       (rt),
        .hazard   (hazard)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vectors for the GPR write arbiter; expected outputs are queued per cycle and checked by a monitor.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbWrite;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        mdValid;
    logic [4:0]  mdAddr;
    logic [31:0] mdData;
    logic        mdReady;
    logic        issueMd;
    logic [4:0]  issueAddr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hazard;
    logic        pipeStall;
    logic        regWrite;
    logic [4:0]  rWriteAddress;
    logic [31:0] rWriteValue;

    typedef struct {
        int          id;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wv;
        logic        rdy;
        logic        hz;
        logic        st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   vec_id   = 0;

    regfile_write_arbiter #(.MD_STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .wbWrite       (wbWrite),
        .wbAddr        (wbAddr),
        .wbData        (wbData),
        .mdValid       (mdValid),
        .mdAddr        (mdAddr),
        .mdData        (mdData),
        .mdReady       (mdReady),
        .issueMd       (issueMd),
        .issueAddr     (issueAddr),
        .rs            (rs),
        .rt            (rt),
        .hazard        (hazard),
        .pipeStall     (pipeStall),
        .regWrite      (regWrite),
        .rWriteAddress (rWriteAddress),
        .rWriteValue   (rWriteValue)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input int id, input string nm, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL vec%0d %s: got %b expected %b", id, nm, act, req);
        end
    endtask

    task automatic check_vec(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, nm, act, req);
        end
    endtask

    // Monitor: inputs settle just after posedge, outputs are compared at the following negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_bit(e.id, "regWrite", regWrite, e.rw);
                check_vec(e.id, "rWriteAddress", {27'd0, rWriteAddress}, {27'd0, e.wa});
                check_vec(e.id, "rWriteValue", rWriteValue, e.wv);
                check_bit(e.id, "mdReady", mdReady, e.rdy);
                check_bit(e.id, "hazard", hazard, e.hz);
                check_bit(e.id, "pipeStall", pipeStall, e.st);
            end
        end
    end

    task automatic idle();
        rst = 0; wbWrite = 0; wbAddr = 0; wbData = 0;
        mdValid = 0; mdAddr = 0; mdData = 0;
        issueMd = 0; issueAddr = 0; rs = 0; rt = 0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wbWrite = 1; wbAddr = a; wbData = d;
    endtask

    task automatic md(input logic [4:0] a, input logic [31:0] d);
        mdValid = 1; mdAddr = a; mdData = d;
    endtask

    // Queue the expected outputs for the currently driven inputs, then advance one cycle.
    task automatic expect_cycle(input logic rw, input logic [4:0] wa, input logic [31:0] wv,
                                input logic rdy, input logic hz, input logic st);
        exp_t e;
        vec_id++;
        e.id = vec_id; e.rw = rw; e.wa = wa; e.wv = wv; e.rdy = rdy; e.hz = hz; e.st = st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;

        // Reset forces the write port, handshake and hazard low.
        idle(); rst = 1;
        expect_cycle(0, 0, 0, 0, 0, 0);
        idle(); rst = 1; md(5'd6, 32'h1111_1111);
        expect_cycle(0, 5'd6, 32'h1111_1111, 0, 0, 0);
        idle();
        expect_cycle(0, 0, 0, 0, 0, 0);

        // Plain writeback lands in the same cycle.
        idle(); wb(5'd5, 32'hDEAD_BEEF);
        expect_cycle(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);

        // Scoreboard set, hazard held through the write cycle, cleared afterwards.
        idle(); issueMd = 1; issueAddr = 5'd9;
        expect_cycle(0, 0, 0, 0, 0, 0);
        idle(); rs = 5'd9;
        expect_cycle(0, 0, 0, 0, 1, 0);
        idle(); rs = 5'd9; md(5'd9, 32'h1234_5678);
        expect_cycle(1, 5'd9, 32'h1234_5678, 1, 1, 0);
        idle(); rs = 5'd9;
        expect_cycle(0, 0, 0, 0, 0, 0);

        // Contention: four blocked cycles, then a forced stall grants mult/div.
        for (int i = 0; i < 4; i++) begin
            idle(); wb(5'd7, 32'hA0 + i); md(5'd10, 32'hCAFE_0000);
            expect_cycle(1, 5'd7, 32'hA0 + i, 0, 0, 0);
        end
        idle(); wb(5'd7, 32'hA4); md(5'd10, 32'hCAFE_0000);
        expect_cycle(1, 5'd10, 32'hCAFE_0000, 1, 0, 1);
        idle(); wb(5'd7, 32'hA4);
        expect_cycle(1, 5'd7, 32'hA4, 0, 0, 0);

        // Register $zero: writes dropped, handshake still completes, never busy.
        idle(); wb(5'd0, 32'h1);
        expect_cycle(0, 5'd0, 32'h1, 0, 0, 0);
        idle(); md(5'd0, 32'h2);
        expect_cycle(0, 5'd0, 32'h2, 1, 0, 0);
        idle(); issueMd = 1; issueAddr = 5'd0;
        expect_cycle(0, 0, 0, 0, 0, 0);
        idle();
        expect_cycle(0, 0, 0, 0, 0, 0);

        // Set and clear of register 3 in one cycle: set wins.
        idle(); issueMd = 1; issueAddr = 5'd3;
        expect_cycle(0, 0, 0, 0, 0, 0);
        idle(); rt = 5'd3; issueMd = 1; issueAddr = 5'd3; md(5'd3, 32'd33);
        expect_cycle(1, 5'd3, 32'd33, 1, 1, 0);
        idle(); rt = 5'd3;
        expect_cycle(0, 0, 0, 0, 1, 0);

        // Drive into STALL with busy[3] set, then reset in the stall cycle.
        for (int i = 0; i < 4; i++) begin
            idle(); rt = 5'd3; wb(5'd4, 32'h40 + i); md(5'd3, 32'd44);
            expect_cycle(1, 5'd4, 32'h40 + i, 0, 1, 0);
        end
        idle(); rst = 1; rt = 5'd3; wb(5'd4, 32'h44); md(5'd3, 32'd44);
        expect_cycle(0, 5'd3, 32'd44, 0, 0, 1);

        // After reset: RUN, busy clear, counter back at zero (needs four fresh blocked cycles).
        for (int i = 0; i < 4; i++) begin
            idle(); rt = 5'd3; wb(5'd4, 32'h50 + i); md(5'd3, 32'd55);
            expect_cycle(1, 5'd4, 32'h50 + i, 0, 0, 0);
        end
        idle(); rt = 5'd3; wb(5'd4, 32'h54); md(5'd3, 32'd55);
        expect_cycle(1, 5'd3, 32'd55, 1, 0, 1);
        idle();
        expect_cycle(0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
